// File: rtl/fmap_stream_reader_if.sv
// Bundles the feature-map buffer read port and the outgoing channel-interleaved stream.
//   master : reader side (drives rd_en/rd_addr, consumes rd_data, drives the stream, sees ready)
//   slave  : buffer + consumer side
// Signals:
//   rd_en, rd_addr     buffer read strobe and address
//   rd_data            buffer data, valid the cycle after rd_en
//   out_data, out_ch   stream payload and its channel index
//   out_last           final beat of a bank read
//   out_valid          stream valid
//   out_ready          stream ready
interface fmap_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 26,
  parameter int unsigned ADDR_WIDTH = 31,
  parameter int unsigned CH_W       = 1
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CH_W-1:0]       out_ch;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output out_data, out_ch, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  out_data, out_ch, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/fmap_stream_reader.sv
// Reads one ping-pong bank of the inter-layer feature-map buffer in pixel-major,
// channel-interleaved order (p0c0, p0c1, ..., p1c0, ...) and streams it over valid/ready.
// The buffer has one cycle of read latency; a 2-entry queue absorbs backpressure, and reads are
// only issued when the queue is guaranteed to have room for them.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, bank       one-cycle start pulse and bank select (sampled together, idle only)
//   busy, done_o      run in progress / one-cycle completion pulse
//   stall_cycles      cycles with out_valid && !out_ready during the last run
//   bus               buffer read port + output stream (fmap_stream_reader_if.master)
// Optional feature: define FMAP_READER_STALL_CNT_EN to build the stall counter; otherwise
// stall_cycles is tied to 0.
module fmap_stream_reader #(
  parameter int unsigned DATA_WIDTH = 26,
  parameter int unsigned CHUNK_SIZE = 16384,
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 31
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        bank,
  output logic                        busy,
  output logic                        done_o,
  output logic [31:0]                 stall_cycles,
  fmap_stream_reader_if.master        bus
);
  localparam int unsigned CH_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned PW   = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam logic [CH_W-1:0]       LastCh = CH_W'(NUM_PORTS - 1);
  localparam logic [PW-1:0]         LastP  = PW'(CHUNK_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ChunkA = ADDR_WIDTH'(CHUNK_SIZE);
  localparam logic [ADDR_WIDTH-1:0] BankA  = ADDR_WIDTH'(NUM_PORTS * CHUNK_SIZE);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PW-1:0]         p_q, p_d;
  logic [CH_W-1:0]       c_q, c_d;
  // Tag of the read whose data arrives on rd_data this cycle.
  logic                  infl_q, infl_d;
  logic [CH_W-1:0]       infl_ch_q, infl_ch_d;
  logic                  infl_last_q, infl_last_d;
  // 2-entry output queue.
  logic [DATA_WIDTH-1:0] q_data_q [2];
  logic [DATA_WIDTH-1:0] q_data_d [2];
  logic [CH_W-1:0]       q_ch_q [2];
  logic [CH_W-1:0]       q_ch_d [2];
  logic [1:0]            q_last_q, q_last_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  pop, issue, is_last;
  logic [2:0]            used;
  logic [ADDR_WIDTH-1:0] cur_addr;

  always_comb begin
    pop      = (cnt_q != 2'd0) && bus.out_ready;
    // Slots committed after this edge; a pop this cycle frees one, which keeps 1 beat/cycle.
    used     = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
    issue    = (state_q == StIssue) && (used < 3'd2);
    is_last  = (c_q == LastCh) && (p_q == LastP);
    cur_addr = base_q + ADDR_WIDTH'(c_q) * ChunkA + ADDR_WIDTH'(p_q);

    state_d     = state_q;
    base_d      = base_q;
    addr_d      = addr_q;
    p_d         = p_q;
    c_d         = c_q;
    infl_d      = issue;
    infl_ch_d   = c_q;
    infl_last_d = is_last;

    case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = bank ? BankA : '0;
          p_d     = '0;
          c_d     = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (issue) begin
          addr_d = cur_addr;
          if (c_q == LastCh) begin
            c_d = '0;
            if (p_q == LastP) state_d = StDrain;
            else              p_d     = p_q + PW'(1);
          end else begin
            c_d = c_q + CH_W'(1);
          end
        end
      end
      StDrain: begin
        // Leave as soon as the final beat is popped so done_o follows it by one cycle.
        if (used == 3'd0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    q_data_d = q_data_q;
    q_ch_d   = q_ch_q;
    q_last_d = q_last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (infl_q) begin
      q_data_d[wr_ptr_q] = bus.rd_data;
      q_ch_d[wr_ptr_q]   = infl_ch_q;
      q_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d           = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + 2'(infl_q) - 2'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      addr_q      <= '0;
      p_q         <= '0;
      c_q         <= '0;
      infl_q      <= 1'b0;
      infl_ch_q   <= '0;
      infl_last_q <= 1'b0;
      q_data_q    <= '{default: '0};
      q_ch_q      <= '{default: '0};
      q_last_q    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      p_q         <= p_d;
      c_q         <= c_d;
      infl_q      <= infl_d;
      infl_ch_q   <= infl_ch_d;
      infl_last_q <= infl_last_d;
      q_data_q    <= q_data_d;
      q_ch_q      <= q_ch_d;
      q_last_q    <= q_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.rd_en     = issue;
  assign bus.rd_addr   = issue ? cur_addr : addr_q;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = q_data_q[rd_ptr_q];
  assign bus.out_ch    = q_ch_q[rd_ptr_q];
  assign bus.out_last  = q_last_q[rd_ptr_q];
  assign busy          = (state_q == StIssue) || (state_q == StDrain);
  assign done_o        = (state_q == StDone);

`ifdef FMAP_READER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == StIdle) && start) begin
      stall_d = '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_fmap_stream_reader.sv
module tb_fmap_stream_reader;
  localparam int unsigned DW = 26;
  localparam int unsigned AW = 31;
  localparam int unsigned CS = 4;
  localparam int unsigned NP = 2;
  localparam int          Budget = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        bank = 1'b0;
  logic        busy, done_o;
  logic [31:0] stall_cycles;

  fmap_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CH_W(1)) bus ();

  fmap_stream_reader #(
    .DATA_WIDTH(DW), .CHUNK_SIZE(CS), .NUM_PORTS(NP), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bank(bank), .busy(busy), .done_o(done_o),
    .stall_cycles(stall_cycles), .bus(bus)
  );

  always #5 clk = ~clk;

  // Buffer model: mem[a] = a, one cycle read latency.
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= DW'(bus.rd_addr);

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          ch;
    logic          last;
  } beat_t;

  typedef struct {
    bit            bnk;
    int            mode;          // 0 ready, 1 pattern 10010, 2 random, 3 low for 20 cycles
    int            restart_beat;  // -1: none
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s", name);
  endtask

  function automatic logic ready_val(input int mode, input int i);
    logic [4:0] pat;
    pat = 5'b01001;
    case (mode)
      0:       return 1'b1;
      1:       return pat[i % 5];
      2:       return 1'($urandom_range(0, 1));
      default: return (i >= 20);
    endcase
  endfunction

  task automatic check_reset_outputs(input string name);
    check(name, {1'b0, busy, done_o, bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_data,
                 bus.out_ch, bus.out_last}, 64'd0);
    check({name, "_stall"}, 64'(stall_cycles), 64'd0);
  endtask

  // Interval i is the clock period following edge i; edge 0 samples start.
  task automatic run(input vec_t v);
    beat_t         exp_q[$];
    beat_t         e;
    int            beats = 0, rd_cnt = 0, rd_early = 0, dones = 0, stalls = 0, oor = 0;
    int            first_rd = -1, first_vld = -1, first_beat_i = -1, last_beat_i = -1;
    int            done_i = -1;
    logic [DW-1:0] got_first = '0, got_last = '0;
    logic [DW+1:0] held = '0;
    bit            restarted = 0, prev_stall = 0;
    logic [AW-1:0] lo, hi;

    for (int p = 0; p < int'(CS); p++) begin
      for (int c = 0; c < int'(NP); c++) begin
        e.data = DW'(int'(v.bnk) * NP * CS + c * CS + p);
        e.ch   = 1'(c);
        e.last = (p == CS - 1) && (c == NP - 1);
        exp_q.push_back(e);
      end
    end
    lo = AW'(int'(v.bnk) * NP * CS);
    hi = lo + AW'(NP * CS - 1);

    @(posedge clk); #1;
    start = 1'b1;
    bank  = v.bnk;
    @(posedge clk); #1;
    for (int i = 0; i < Budget; i++) begin
      bus.out_ready = ready_val(v.mode, i);
      if (!restarted && v.restart_beat >= 0 && beats == v.restart_beat) begin
        start     = 1'b1;
        bank      = ~v.bnk;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (i == 0) check("busy_after_start", 64'(busy), 64'd1);
      if (bus.rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = i;
        if (v.mode == 3 && i < 20) rd_early++;
        if (bus.rd_addr < lo || bus.rd_addr > hi) oor++;
      end
      if (bus.out_valid) begin
        if (first_vld < 0) first_vld = i;
        if (prev_stall) check("hold_stable", 64'({bus.out_data, bus.out_ch, bus.out_last}),
                              64'(held));
      end
      if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        prev_stall = 1;
        held = {bus.out_data, bus.out_ch, bus.out_last};
      end else begin
        prev_stall = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail("extra_beat");
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(bus.out_data), 64'(e.data));
          check("beat_ch", 64'(bus.out_ch), 64'(e.ch));
          check("beat_last", 64'(bus.out_last), 64'(e.last));
        end
        if (first_beat_i < 0) begin
          first_beat_i = i;
          got_first    = bus.out_data;
        end
        got_last    = bus.out_data;
        last_beat_i = i;
        beats++;
      end
      if (done_o) begin
        dones++;
        if (done_i < 0) begin
          done_i = i;
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
      if (done_i >= 0 && i >= done_i + 3) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("beat_count", 64'(beats), 64'(NP * CS));
    check("model_drained", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(dones), 64'd1);
    check("first_rd_en_lat", 64'(first_rd), 64'd0);
    check("first_valid_lat", 64'(first_vld), 64'd2);
    check("done_after_last", 64'(done_i), 64'(last_beat_i + 1));
    check("first_data", 64'(got_first), 64'(v.exp_first));
    check("last_data", 64'(got_last), 64'(v.exp_last));
    check("rd_addr_out_of_bank", 64'(oor), 64'd0);
    check("rd_en_count", 64'(rd_cnt), 64'(NP * CS));
`ifdef FMAP_READER_STALL_CNT_EN
    check("stall_cycles", 64'(stall_cycles), 64'(stalls));
`else
    check("stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    if (v.mode == 0) check("back_to_back", 64'(last_beat_i - first_beat_i), 64'(NP * CS - 1));
    if (v.mode == 3) check("rd_en_while_blocked_le2", 64'(rd_early <= 2), 64'd1);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t rv;
    int   beats;
    int   dn;

    vecs[0] = '{bnk: 1'b0, mode: 0, restart_beat: -1, exp_first: 0, exp_last: 7};
    vecs[1] = '{bnk: 1'b1, mode: 0, restart_beat: -1, exp_first: 8, exp_last: 15};
    vecs[2] = '{bnk: 1'b0, mode: 1, restart_beat: -1, exp_first: 0, exp_last: 7};
    vecs[3] = '{bnk: 1'b0, mode: 0, restart_beat: 3,  exp_first: 0, exp_last: 7};
    vecs[4] = '{bnk: 1'b1, mode: 1, restart_beat: 5,  exp_first: 8, exp_last: 15};
    vecs[5] = '{bnk: 1'b0, mode: 3, restart_beat: -1, exp_first: 0, exp_last: 7};

    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_state");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    for (int k = 0; k < 6; k++) run(vecs[k]);

    // Reset after the fourth beat: everything clears at once and no done_o follows.
    @(posedge clk); #1;
    start = 1'b1; bank = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    beats = 0;
    for (int i = 0; i < Budget && beats < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) beats++;
      if (beats < 4) begin @(posedge clk); #1; end
    end
    check("pre_reset_beats", 64'(beats), 64'd4);
    @(posedge clk); #1 rst = 1'b1;
    #1 check_reset_outputs("mid_run_reset");
    dn = 0;
    repeat (2) begin @(negedge clk); if (done_o) dn++; end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin @(negedge clk); if (done_o) dn++; end
    check("no_done_after_reset", 64'(dn), 64'd0);
    run(vecs[0]);

    // Random backpressure, bank and ignored restart.
    for (int k = 0; k < 6; k++) begin
      rv.bnk          = 1'($urandom_range(0, 1));
      rv.mode         = 2;
      rv.restart_beat = int'($urandom_range(0, 8)) - 1;
      rv.exp_first    = DW'(int'(rv.bnk) * NP * CS);
      rv.exp_last     = DW'(int'(rv.bnk) * NP * CS + NP * CS - 1);
      run(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
